// File: rtl/gpio_pkg.sv
// ----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the second-generation GPIO block (gpio_irq).
//
// Contents:
//   - byte offsets of every register in the GPIO register map
//   - reg_idx_e : one enum value per register, plus REG_NONE for holes
//   - decode_offset() : turns a decoded byte offset into a reg_idx_e
// ----------------------------------------------------------------------------
package gpio_pkg;

    // Register offsets, in bytes, relative to the block base address.
    localparam logic [31:0] OFS_OUT         = 32'h00;
    localparam logic [31:0] OFS_IN          = 32'h04;
    localparam logic [31:0] OFS_IN_DBNC     = 32'h08;
    localparam logic [31:0] OFS_OUT_EN      = 32'h0C;
    localparam logic [31:0] OFS_OUT_SET     = 32'h10;
    localparam logic [31:0] OFS_OUT_CLR     = 32'h14;
    localparam logic [31:0] OFS_IRQ_EN      = 32'h18;
    localparam logic [31:0] OFS_IRQ_STATUS  = 32'h1C;
    localparam logic [31:0] OFS_IRQ_RISE    = 32'h20;
    localparam logic [31:0] OFS_IRQ_FALL    = 32'h24;
    localparam logic [31:0] OFS_DBNC_PERIOD = 32'h28;

    // One entry per register; REG_NONE marks any offset that is not mapped,
    // so both the write and read paths can simply ignore it.
    typedef enum logic [3:0] {
        REG_OUT,
        REG_IN,
        REG_IN_DBNC,
        REG_OUT_EN,
        REG_OUT_SET,
        REG_OUT_CLR,
        REG_IRQ_EN,
        REG_IRQ_STATUS,
        REG_IRQ_RISE,
        REG_IRQ_FALL,
        REG_DBNC_PERIOD,
        REG_NONE
    } reg_idx_e;

    // Map a byte offset (already stripped of the ignored upper address bits)
    // onto a register index. Unaligned or out-of-map offsets give REG_NONE.
    function automatic reg_idx_e decode_offset(input logic [31:0] ofs);
        reg_idx_e idx;
        case (ofs)
            OFS_OUT:         idx = REG_OUT;
            OFS_IN:          idx = REG_IN;
            OFS_IN_DBNC:     idx = REG_IN_DBNC;
            OFS_OUT_EN:      idx = REG_OUT_EN;
            OFS_OUT_SET:     idx = REG_OUT_SET;
            OFS_OUT_CLR:     idx = REG_OUT_CLR;
            OFS_IRQ_EN:      idx = REG_IRQ_EN;
            OFS_IRQ_STATUS:  idx = REG_IRQ_STATUS;
            OFS_IRQ_RISE:    idx = REG_IRQ_RISE;
            OFS_IRQ_FALL:    idx = REG_IRQ_FALL;
            OFS_DBNC_PERIOD: idx = REG_DBNC_PERIOD;
            default:         idx = REG_NONE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/gpio_irq_dbnc.sv
// ----------------------------------------------------------------------------
// gpio_irq_dbnc
// Debounce and edge detection for the synchronised GPIO inputs.
//
// A shared prescaler counts 0..period-1 and produces a one-cycle tick on the
// wrap. On each tick every pin compares its current level with the level it
// saw on the previous tick; only if both agree does the debounced value
// follow. A level therefore has to be stable across two consecutive ticks,
// which takes one to two periods. period == 0 bypasses the filter.
//
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   period     debounce period in clock cycles (0 = bypass)
//   period_wr  pulses when software writes the period; restarts the prescaler
//   gp_sync    synchronised pin levels
//   dbnc       debounced pin levels
//   rise       one-cycle pulse per pin when dbnc goes 0 -> 1
//   fall       one-cycle pulse per pin when dbnc goes 1 -> 0
// ----------------------------------------------------------------------------
module gpio_irq_dbnc #(
    parameter int unsigned Width    = 16,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CntWidth-1:0] period,
    input  logic                period_wr,
    input  logic [Width-1:0]    gp_sync,
    output logic [Width-1:0]    dbnc,
    output logic [Width-1:0]    rise,
    output logic [Width-1:0]    fall
);

    logic [CntWidth-1:0] presc_cnt;
    logic                bypass;
    logic                tick;
    logic [Width-1:0]    sample;
    logic [Width-1:0]    dbnc_q;
    logic [Width-1:0]    agree;

    // A zero period means no filtering at all; the prescaler is parked.
    assign bypass = (period == '0);
    assign tick   = !bypass && (presc_cnt == (period - CntWidth'(1)));

    // Pins whose level has not changed since the last tick.
    assign agree = ~(gp_sync ^ sample);

    // Prescaler: restarts from zero whenever the period is rewritten so a
    // new, shorter period can never leave the counter stranded above it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_cnt <= '0;
        end else if (period_wr || bypass || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + CntWidth'(1);
        end
    end

    // Per-pin filter. The sample register always tracks the pin on a tick;
    // the debounced value only moves for pins that agreed with that sample.
    // dbnc_q is the one-cycle history used to spot edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample <= '0;
            dbnc   <= '0;
            dbnc_q <= '0;
        end else begin
            dbnc_q <= dbnc;
            if (bypass) begin
                sample <= gp_sync;
                dbnc   <= gp_sync;
            end else if (tick) begin
                sample <= gp_sync;
                dbnc   <= (dbnc & ~agree) | (gp_sync & agree);
            end
        end
    end

    // Edge pulses last exactly one cycle, the cycle after dbnc changes.
    assign rise = dbnc & ~dbnc_q;
    assign fall = ~dbnc & dbnc_q;

endmodule

// File: rtl/gpio_irq.sv
// ----------------------------------------------------------------------------
// gpio_irq
// Memory-mapped GPIO with atomic set/clear of the outputs, a programmable
// input debounce and per-pin rising/falling edge interrupts that collect in a
// write-one-to-clear status register and drive a single level IRQ line.
//
// Ports:
//   clk_i            clock
//   rst_i            asynchronous active-high reset
//   device_req_i     bus request (one cycle per access)
//   device_addr_i    byte address; only the low RegAddr bits are decoded
//   device_we_i      1 = write, 0 = read
//   device_be_i      byte enables for writes
//   device_wdata_i   write data
//   device_rvalid_o  response valid, one cycle after every request
//   device_rdata_o   read data (0 for write responses and unmapped reads)
//   gp_i             asynchronous input pins
//   gp_o             output pin values
//   gp_o_en          output pin enables
//   irq_o            level interrupt to the interrupt controller
// ----------------------------------------------------------------------------
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int unsigned GpiWidth     = 16,
    parameter int unsigned GpoWidth     = 16,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddr      = 12,
    parameter int unsigned DbncCntWidth = 16,
    parameter int unsigned DbncDefault  = 500
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 device_req_i,
    input  logic [AddrWidth-1:0] device_addr_i,
    input  logic                 device_we_i,
    input  logic [3:0]           device_be_i,
    input  logic [DataWidth-1:0] device_wdata_i,
    output logic                 device_rvalid_o,
    output logic [DataWidth-1:0] device_rdata_o,
    input  logic [GpiWidth-1:0]  gp_i,
    output logic [GpoWidth-1:0]  gp_o,
    output logic [GpoWidth-1:0]  gp_o_en,
    output logic                 irq_o
);

    // Only the first four bytes of the data bus have an enable bit.
    localparam int unsigned MaskBits = (DataWidth < 32) ? DataWidth : 32;

    logic [31:0]             reg_ofs;
    reg_idx_e                reg_idx;
    logic                    wr_en;
    logic [DataWidth-1:0]    wmask;
    logic [DataWidth-1:0]    wbits;
    logic [DataWidth-1:0]    rd_val;

    logic [GpiWidth-1:0]     gp_meta;
    logic [GpiWidth-1:0]     gp_sync;
    logic [GpiWidth-1:0]     dbnc;
    logic [GpiWidth-1:0]     rise;
    logic [GpiWidth-1:0]     fall;

    logic [GpiWidth-1:0]     irq_en;
    logic [GpiWidth-1:0]     irq_status;
    logic [GpiWidth-1:0]     irq_rise;
    logic [GpiWidth-1:0]     irq_fall;
    logic [GpiWidth-1:0]     status_w1c;
    logic [GpiWidth-1:0]     status_set;
    logic [DbncCntWidth-1:0] dbnc_period;
    logic                    period_wr;

    logic                    unused_bits;

    // Address decode: upper address bits are don't-care, so the low RegAddr
    // bits alone select the register.
    assign reg_ofs = 32'(device_addr_i[RegAddr-1:0]);
    assign reg_idx = decode_offset(reg_ofs);
    assign wr_en   = device_req_i && device_we_i;

    // Expand the byte enables into a per-bit mask; lanes beyond byte 3 stay
    // masked off, and bits above each register's width are simply dropped by
    // the slicing below.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < MaskBits; i++) begin
            wmask[i] = device_be_i[i / 8];
        end
    end

    assign wbits = device_wdata_i & wmask;

    // Upper address bits and the write lanes above the pin widths are
    // intentionally ignored.
    assign unused_bits = ^{device_addr_i, wbits, wmask};

    // Two-flop synchroniser; nothing downstream ever sees raw gp_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gp_meta <= '0;
            gp_sync <= '0;
        end else begin
            gp_meta <= gp_i;
            gp_sync <= gp_meta;
        end
    end

    assign period_wr = wr_en && (reg_idx == REG_DBNC_PERIOD);

    gpio_irq_dbnc #(
        .Width    (GpiWidth),
        .CntWidth (DbncCntWidth)
    ) u_dbnc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .period    (dbnc_period),
        .period_wr (period_wr),
        .gp_sync   (gp_sync),
        .dbnc      (dbnc),
        .rise      (rise),
        .fall      (fall)
    );

    // Software-writable configuration and output registers. Every write is
    // a byte-masked read-modify-write; SET/CLR only touch bits written as 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gp_o        <= '0;
            gp_o_en     <= '0;
            irq_en      <= '0;
            irq_rise    <= '0;
            irq_fall    <= '0;
            dbnc_period <= DbncCntWidth'(DbncDefault);
        end else if (wr_en) begin
            case (reg_idx)
                REG_OUT:         gp_o        <= (gp_o & ~wmask[GpoWidth-1:0]) | wbits[GpoWidth-1:0];
                REG_OUT_EN:      gp_o_en     <= (gp_o_en & ~wmask[GpoWidth-1:0]) | wbits[GpoWidth-1:0];
                REG_OUT_SET:     gp_o        <= gp_o | wbits[GpoWidth-1:0];
                REG_OUT_CLR:     gp_o        <= gp_o & ~wbits[GpoWidth-1:0];
                REG_IRQ_EN:      irq_en      <= (irq_en & ~wmask[GpiWidth-1:0]) | wbits[GpiWidth-1:0];
                REG_IRQ_RISE:    irq_rise    <= (irq_rise & ~wmask[GpiWidth-1:0]) | wbits[GpiWidth-1:0];
                REG_IRQ_FALL:    irq_fall    <= (irq_fall & ~wmask[GpiWidth-1:0]) | wbits[GpiWidth-1:0];
                REG_DBNC_PERIOD: dbnc_period <= (dbnc_period & ~wmask[DbncCntWidth-1:0])
                                                | wbits[DbncCntWidth-1:0];
                default: ;
            endcase
        end
    end

    // Status collects enabled edges regardless of IRQ_EN. The clear is
    // applied before the new events are ORed in, so an edge arriving in the
    // same cycle as its W1C keeps the bit set.
    assign status_w1c = (wr_en && (reg_idx == REG_IRQ_STATUS)) ? wbits[GpiWidth-1:0] : '0;
    assign status_set = (rise & irq_rise) | (fall & irq_fall);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~status_w1c) | status_set;
        end
    end

    // The IRQ line is registered off the masked status, giving a clean
    // glitch-free level to the interrupt controller.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(irq_status & irq_en);
        end
    end

    // Read mux. SET/CLR and holes fall through to zero; narrower registers
    // are zero-extended to the bus width.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_OUT:         rd_val = DataWidth'(gp_o);
            REG_IN:          rd_val = DataWidth'(gp_sync);
            REG_IN_DBNC:     rd_val = DataWidth'(dbnc);
            REG_OUT_EN:      rd_val = DataWidth'(gp_o_en);
            REG_IRQ_EN:      rd_val = DataWidth'(irq_en);
            REG_IRQ_STATUS:  rd_val = DataWidth'(irq_status);
            REG_IRQ_RISE:    rd_val = DataWidth'(irq_rise);
            REG_IRQ_FALL:    rd_val = DataWidth'(irq_fall);
            REG_DBNC_PERIOD: rd_val = DataWidth'(dbnc_period);
            default:         rd_val = '0;
        endcase
    end

    // Every request gets exactly one response a cycle later; writes answer
    // with zero data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_rdata_o  <= (device_req_i && !device_we_i) ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_gpio_irq.sv
// ----------------------------------------------------------------------------
// tb_gpio_irq
// Self-checking bench for gpio_irq: a table of single bus transactions with
// hand-computed responses, followed by directed sequences for debounce
// timing, interrupt latency, W1C/event collision and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_gpio_irq;

    logic        clk_i;
    logic        rst_i;
    logic        device_req_i;
    logic [31:0] device_addr_i;
    logic        device_we_i;
    logic [3:0]  device_be_i;
    logic [31:0] device_wdata_i;
    logic        device_rvalid_o;
    logic [31:0] device_rdata_o;
    logic [15:0] gp_i;
    logic [15:0] gp_o;
    logic [15:0] gp_o_en;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic [15:0] exp_gpo;
        logic [15:0] exp_en;
    } vec_t;

    vec_t vecs[21];

    gpio_irq dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .device_req_i    (device_req_i),
        .device_addr_i   (device_addr_i),
        .device_we_i     (device_we_i),
        .device_be_i     (device_be_i),
        .device_wdata_i  (device_wdata_i),
        .device_rvalid_o (device_rvalid_o),
        .device_rdata_o  (device_rdata_o),
        .gp_i            (gp_i),
        .gp_o            (gp_o),
        .gp_o_en         (gp_o_en),
        .irq_o           (irq_o)
    );

    // 10 ns clock; inputs change on the falling edge, outputs are sampled there.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hard stop in case a sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus transaction: request for one cycle, return at the falling edge
    // where the response is visible.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk_i);
        device_req_i   = 1'b1;
        device_we_i    = we;
        device_addr_i  = addr;
        device_wdata_i = wdata;
        device_be_i    = be;
        @(negedge clk_i);
        device_req_i   = 1'b0;
        device_we_i    = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, addr, wdata, 4'hF);
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        applyStimulus(1'b0, addr, 32'h0, 4'h0);
        data = device_rdata_o;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] seen;
        int          first;

        //          we    addr          wdata         be    rdata         gp_o     gp_o_en
        vecs[0]  = '{1'b1, 32'h00,       32'h000000A5, 4'h1, 32'h0,        16'h00A5, 16'h0000};
        vecs[1]  = '{1'b1, 32'h00,       32'h0000FF00, 4'h2, 32'h0,        16'hFFA5, 16'h0000};
        vecs[2]  = '{1'b0, 32'h00,       32'h0,        4'h0, 32'h0000FFA5, 16'hFFA5, 16'h0000};
        vecs[3]  = '{1'b1, 32'h00,       32'h000000F0, 4'hF, 32'h0,        16'h00F0, 16'h0000};
        vecs[4]  = '{1'b1, 32'h10,       32'h0000000F, 4'hF, 32'h0,        16'h00FF, 16'h0000};
        vecs[5]  = '{1'b1, 32'h14,       32'h000000F0, 4'hF, 32'h0,        16'h000F, 16'h0000};
        vecs[6]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'h0,        16'h000F, 16'h0000};
        vecs[7]  = '{1'b0, 32'h14,       32'h0,        4'h0, 32'h0,        16'h000F, 16'h0000};
        vecs[8]  = '{1'b1, 32'h0C,       32'hFFFF1234, 4'hF, 32'h0,        16'h000F, 16'h1234};
        vecs[9]  = '{1'b0, 32'h0C,       32'h0,        4'h0, 32'h00001234, 16'h000F, 16'h1234};
        vecs[10] = '{1'b1, 32'h3C,       32'hFFFFFFFF, 4'hF, 32'h0,        16'h000F, 16'h1234};
        vecs[11] = '{1'b0, 32'h3C,       32'h0,        4'h0, 32'h0,        16'h000F, 16'h1234};
        vecs[12] = '{1'b1, 32'h00,       32'hFFFFFFFF, 4'h4, 32'h0,        16'h000F, 16'h1234};
        vecs[13] = '{1'b0, 32'h28,       32'h0,        4'h0, 32'h000001F4, 16'h000F, 16'h1234};
        vecs[14] = '{1'b1, 32'h18,       32'h0000ABCD, 4'h3, 32'h0,        16'h000F, 16'h1234};
        vecs[15] = '{1'b0, 32'h18,       32'h0,        4'h0, 32'h0000ABCD, 16'h000F, 16'h1234};
        vecs[16] = '{1'b1, 32'h18,       32'h00000000, 4'hF, 32'h0,        16'h000F, 16'h1234};
        vecs[17] = '{1'b0, 32'h18,       32'h0,        4'h0, 32'h0,        16'h000F, 16'h1234};
        vecs[18] = '{1'b0, 32'h10000000, 32'h0,        4'h0, 32'h0000000F, 16'h000F, 16'h1234};
        vecs[19] = '{1'b1, 32'h10,       32'h0000FF00, 4'h1, 32'h0,        16'h000F, 16'h1234};
        vecs[20] = '{1'b0, 32'h04,       32'h0,        4'h0, 32'h0,        16'h000F, 16'h1234};

        rst_i          = 1'b1;
        device_req_i   = 1'b0;
        device_we_i    = 1'b0;
        device_addr_i  = 32'h0;
        device_wdata_i = 32'h0;
        device_be_i    = 4'h0;
        gp_i           = 16'h0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        checkOutput("reset_gp_o", gp_o, 0);
        checkOutput("reset_gp_o_en", gp_o_en, 0);
        checkOutput("reset_rvalid", device_rvalid_o, 0);
        checkOutput("reset_rdata", device_rdata_o, 0);
        checkOutput("reset_irq", irq_o, 0);
        rst_i = 1'b0;

        // Table of single transactions.
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            checkOutput($sformatf("vec%0d_rvalid", i), device_rvalid_o, 1);
            checkOutput($sformatf("vec%0d_rdata", i), device_rdata_o, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_gp_o", i), gp_o, vecs[i].exp_gpo);
            checkOutput($sformatf("vec%0d_gp_o_en", i), gp_o_en, vecs[i].exp_en);
        end
        @(negedge clk_i);
        checkOutput("rvalid_drops", device_rvalid_o, 0);

        // Debounce with period 4: a 3-cycle glitch must never reach IN_DBNC.
        busWrite(32'h28, 32'h4);
        @(negedge clk_i);
        device_req_i  = 1'b1;
        device_we_i   = 1'b0;
        device_addr_i = 32'h08;
        gp_i[0]       = 1'b1;
        repeat (3) @(negedge clk_i);
        gp_i[0] = 1'b0;
        seen = 32'h0;
        repeat (24) begin
            @(negedge clk_i);
            seen |= device_rdata_o;
        end
        checkOutput("glitch_in_dbnc", seen, 0);

        // Held rise: IN follows after the synchroniser, IN_DBNC 4..8 cycles later.
        @(negedge clk_i);
        device_addr_i = 32'h04;
        gp_i[0]       = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("in_before_sync", device_rdata_o, 0);
        @(negedge clk_i);
        checkOutput("in_after_sync", device_rdata_o, 1);
        device_addr_i = 32'h08;
        first = 0;
        for (int m = 4; m <= 40 && first == 0; m++) begin
            @(negedge clk_i);
            if (device_rdata_o[0]) first = m;
        end
        checkOutput("dbnc_latency_in_window", 32'((first >= 7) && (first <= 11)), 1);
        device_req_i = 1'b0;

        // Rising-edge interrupt in bypass mode.
        busWrite(32'h28, 32'h0);
        busWrite(32'h20, 32'h1);
        busWrite(32'h18, 32'h1);
        gp_i[0] = 1'b0;
        repeat (6) @(negedge clk_i);
        gp_i[0] = 1'b1;
        repeat (4) @(negedge clk_i);
        checkOutput("irq_not_yet", irq_o, 0);
        @(negedge clk_i);
        checkOutput("irq_rise", irq_o, 1);
        busRead(32'h1C, rd);
        checkOutput("status_rise", rd, 32'h1);
        busWrite(32'h1C, 32'h1);
        @(negedge clk_i);
        checkOutput("irq_after_w1c", irq_o, 0);
        busRead(32'h1C, rd);
        checkOutput("status_after_w1c", rd, 32'h0);

        // W1C landing on the same edge as a new rise: the event wins.
        gp_i[0] = 1'b0;
        repeat (6) @(negedge clk_i);
        gp_i[0] = 1'b1;
        repeat (3) @(negedge clk_i);
        device_req_i   = 1'b1;
        device_we_i    = 1'b1;
        device_addr_i  = 32'h1C;
        device_wdata_i = 32'h1;
        device_be_i    = 4'hF;
        @(negedge clk_i);
        device_req_i = 1'b0;
        device_we_i  = 1'b0;
        busRead(32'h1C, rd);
        checkOutput("status_event_wins", rd, 32'h1);
        busWrite(32'h1C, 32'h1);
        busRead(32'h1C, rd);
        checkOutput("status_cleared", rd, 32'h0);

        // Falling edge with IRQ_EN masked, then unmasked.
        gp_i[1] = 1'b1;
        repeat (6) @(negedge clk_i);
        busWrite(32'h18, 32'h0);
        busWrite(32'h24, 32'h2);
        gp_i[1] = 1'b0;
        repeat (6) @(negedge clk_i);
        busRead(32'h1C, rd);
        checkOutput("status_fall", rd, 32'h2);
        checkOutput("irq_masked", irq_o, 0);
        busWrite(32'h18, 32'h2);
        @(negedge clk_i);
        checkOutput("irq_unmasked", irq_o, 1);

        // Asynchronous reset in the middle of a debounce with irq_o high.
        busWrite(32'h28, 32'h4);
        gp_i[0] = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("irq_before_reset", irq_o, 1);
        #3;
        rst_i = 1'b1;
        #1;
        checkOutput("async_gp_o", gp_o, 0);
        checkOutput("async_gp_o_en", gp_o_en, 0);
        checkOutput("async_irq", irq_o, 0);
        checkOutput("async_rvalid", device_rvalid_o, 0);
        checkOutput("async_rdata", device_rdata_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        busRead(32'h28, rd);
        checkOutput("period_default", rd, 32'd500);
        busRead(32'h3C, rd);
        checkOutput("unmapped_read", rd, 32'h0);
        busRead(32'h1C, rd);
        checkOutput("status_after_reset", rd, 32'h0);
        busRead(32'h18, rd);
        checkOutput("irq_en_after_reset", rd, 32'h0);
        busRead(32'h08, rd);
        checkOutput("dbnc_after_reset", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
